sift_dir_quant: RTL and testbench

Pipelined gradient-orientation quantiser for the SIFT descriptor and orientation-assignment path. It takes a signed gradient pair (dx, dy) and a reference (dominant) orientation bin, and returns the gradient's direction bin rotated relative to that reference, modulo NBINS. It replaces fixed direction lookup ROMs with a parametrised, streaming, back-pressurable unit. It sits between the gradient calculator and the histogram accumulators.

---
 rtl/sift_dir_quant.sv | 178 +++++++++++++++++
 tb/tb_sift_dir_quant.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sift_dir_quant.sv
// sift_dir_quant: 3-stage pipelined gradient orientation quantiser.
// Maps a signed (dx, dy) to one of NBINS direction bins, rotated by ref_bin.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, dx, dy, ref_bin;
//        out_valid/out_ready, out_bin, out_zero, out_mag (SIFT_DIR_MAG_EN only).
// Option: define SIFT_DIR_MAG_EN to add the out_mag = mx + (mn >> 1) output.
module sift_dir_quant #(
   parameter  int W     = 9,
   parameter  int NBINS = 32,
   localparam int BW    = $clog2(NBINS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  dx,
   input  logic [W-1:0]  dy,
   input  logic [BW-1:0] ref_bin,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_bin,
   output logic          out_zero
`ifdef SIFT_DIR_MAG_EN
   ,
   output logic [W:0]    out_mag
`endif
);

   localparam int BPO = NBINS / 8;
   localparam int NT  = BPO - 1;
   localparam logic [BW-1:0] LAST = BW'(BPO - 1);

   generate
      if (!(NBINS == 8 || NBINS == 16 || NBINS == 32)) begin : g_bad_nbins
         $error("sift_dir_quant: NBINS must be 8, 16 or 32");
      end
   endgenerate

   // tan() of the in-octant bin boundaries, Q0.12
   function automatic logic [11:0] thr(input int k);
      logic [11:0] t;
      t = 12'd0;
      if (NBINS == 32) begin
         if (k == 0)      t = 12'd815;
         else if (k == 1) t = 12'd1697;
         else             t = 12'd2737;
      end else if (NBINS == 16) begin
         t = 12'd1697;
      end
      return t;
   endfunction

   // global advance: every stage moves or none does
   logic w_en;
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   // ---------------- S1: abs, quadrant, half-quadrant
   logic          w_dx_neg, w_dy_neg, w_dx_pos, w_dy_pos, w_zero;
   logic [W-1:0]  w_ax, w_ay, w_u, w_v, w_mn, w_mx;
   logic [1:0]    w_q;
   logic          w_h;

   assign w_dx_neg = dx[W-1];
   assign w_dy_neg = dy[W-1];
   assign w_dx_pos = !w_dx_neg && (|dx);
   assign w_dy_pos = !w_dy_neg && (|dy);
   assign w_zero   = !(|dx) && !(|dy);

   // -(-2^(W-1)) wraps to 2^(W-1), read back as unsigned
   assign w_ax = w_dx_neg ? (~dx + W'(1)) : dx;
   assign w_ay = w_dy_neg ? (~dy + W'(1)) : dy;

   always_comb begin
      w_q = 2'd0;
      unique case (1'b1)
         w_dx_pos && !w_dy_neg: w_q = 2'd0;
         !w_dx_pos && w_dy_pos: w_q = 2'd1;
         w_dx_neg && !w_dy_pos: w_q = 2'd2;
         !w_dx_neg && w_dy_neg: w_q = 2'd3;
         default:               w_q = 2'd0;
      endcase
   end

   // odd quadrants swap the roles of |dx| and |dy|
   assign w_u  = w_q[0] ? w_ay : w_ax;
   assign w_v  = w_q[0] ? w_ax : w_ay;
   assign w_h  = (w_v >= w_u);
   assign w_mn = w_h ? w_u : w_v;
   assign w_mx = w_h ? w_v : w_u;

   logic          r1_v, r1_h, r1_z;
   logic [1:0]    r1_q;
   logic [W-1:0]  r1_mn, r1_mx;
   logic [BW-1:0] r1_ref;

   // ---------------- S2: threshold compares, raw bin
   logic [W+11:0] w_lhs, w_rhs;
   logic [BW-1:0] w_cnt_ge, w_cnt_gt, w_fine, w_oct, w_raw;

   assign w_oct = BW'({r1_q, r1_h}) << (BW - 3);

   always_comb begin
      w_cnt_ge = '0;
      w_cnt_gt = '0;
      w_rhs    = '0;
      w_lhs    = {r1_mn, 12'd0};
      for (int k = 0; k < NT; k++) begin
         w_rhs = {{12{1'b0}}, r1_mx} * {{W{1'b0}}, thr(k)};
         if (w_lhs >= w_rhs) w_cnt_ge = w_cnt_ge + BW'(1);
         if (w_lhs > w_rhs)  w_cnt_gt = w_cnt_gt + BW'(1);
      end
      // odd octants count down from the far edge so ties still go high
      w_fine = r1_h ? (LAST - w_cnt_gt) : w_cnt_ge;
      w_raw  = r1_z ? '0 : (w_oct + w_fine);
   end

   logic          r2_v, r2_z;
   logic [BW-1:0] r2_raw, r2_ref;

   // ---------------- S3: reference offset
   logic          r3_v, r3_z;
   logic [BW-1:0] r3_bin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v   <= 1'b0;
         r1_h   <= 1'b0;
         r1_z   <= 1'b0;
         r1_q   <= '0;
         r1_mn  <= '0;
         r1_mx  <= '0;
         r1_ref <= '0;
         r2_v   <= 1'b0;
         r2_z   <= 1'b0;
         r2_raw <= '0;
         r2_ref <= '0;
         r3_v   <= 1'b0;
         r3_z   <= 1'b0;
         r3_bin <= '0;
      end else if (w_en) begin
         r1_v   <= in_valid;
         r1_h   <= w_h;
         r1_z   <= w_zero;
         r1_q   <= w_q;
         r1_mn  <= w_mn;
         r1_mx  <= w_mx;
         r1_ref <= ref_bin;
         r2_v   <= r1_v;
         r2_z   <= r1_z;
         r2_raw <= w_raw;
         r2_ref <= r1_ref;
         r3_v   <= r2_v;
         r3_z   <= r2_z;
         r3_bin <= r2_raw - r2_ref;
      end
   end

   assign out_valid = r3_v;
   assign out_bin   = r3_bin;
   assign out_zero  = r3_z;

`ifdef SIFT_DIR_MAG_EN
   logic [W:0] r2_mag, r3_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_mag <= '0;
         r3_mag <= '0;
      end else if (w_en) begin
         r2_mag <= {1'b0, r1_mx} + {2'b00, r1_mn[W-1:1]};
         r3_mag <= r2_mag;
      end
   end

   assign out_mag = r3_mag;
`endif

endmodule

// File: tb/tb_sift_dir_quant.sv
// tb_sift_dir_quant: directed + scoreboard bench for sift_dir_quant.
// W = 9, NBINS = 32; out_mag checks only when SIFT_DIR_MAG_EN is defined.
module tb_sift_dir_quant;

   localparam int W  = 9;
   localparam int BW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dx, dy;
   logic [BW-1:0] ref_bin;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_bin;
   logic          out_zero;
`ifdef SIFT_DIR_MAG_EN
   logic [W:0]    out_mag;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sift_dir_quant #(.W(9), .NBINS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dx        (dx),
      .dy        (dy),
      .ref_bin   (ref_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_zero  (out_zero)
`ifdef SIFT_DIR_MAG_EN
      ,
      .out_mag   (out_mag)
`endif
   );

   // reference: rotate clockwise into the first quadrant, then bin
   function automatic logic [5:0] model(input int x, input int y, input int r);
      int u, v, t, q, h, mn, mx, ge, gt, raw, b;
      int th[3];
      th  = '{815, 1697, 2737};
      raw = 0;
      if (x != 0 || y != 0) begin
         u = x;
         v = y;
         q = 0;
         while (!(u > 0 && v >= 0)) begin
            t = u;
            u = v;
            v = -t;
            q++;
         end
         h  = (v >= u) ? 1 : 0;
         mn = h ? u : v;
         mx = h ? v : u;
         ge = 0;
         gt = 0;
         for (int k = 0; k < 3; k++) begin
            if (mn * 4096 >= mx * th[k]) ge++;
            if (mn * 4096 > mx * th[k])  gt++;
         end
         raw = (2 * q + h) * 4 + (h ? (3 - gt) : ge);
      end
      b = (raw - r + 64) % 32;
      return {(x == 0 && y == 0), b[4:0]};
   endfunction

   task automatic drive_beat(input int x, input int y, input int r);
      dx       = x[W-1:0];
      dy       = y[W-1:0];
      ref_bin  = r[BW-1:0];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // cycles from drive to out_valid; -1 when the bound expires
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dx        = '0;
      dy        = '0;
      ref_bin   = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_bin !== 5'd0 || out_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset data: got bin %0d zero %b want 0 0", out_bin, out_zero);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset in_ready: got %b want 1", in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_axes;
      int tx[4] = '{100, 0, -100, 0};
      int ty[4] = '{0, 100, 0, -100};
      logic [4:0] te[4] = '{5'd0, 5'd8, 5'd16, 5'd24};
      int lat;
      for (int i = 0; i < 4; i++) begin
         drive_beat(tx[i], ty[i], 0);
         wait_out(lat);
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL axes[%0d] latency: got %0d want 3", i, lat);
         end
         checks++;
         if (out_bin !== te[i] || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL axes[%0d] bin: got %0d/%b want %0d/0",
                     i, out_bin, out_zero, te[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_boundaries;
      int tx[3] = '{100, 100, -256};
      int ty[3] = '{20, 100, -256};
      logic [4:0] te[3] = '{5'd1, 5'd4, 5'd20};
      int lat;
      for (int i = 0; i < 3; i++) begin
         drive_beat(tx[i], ty[i], 0);
         wait_out(lat);
         checks++;
         if (lat != 3 || out_bin !== te[i]) begin
            errors++;
            $display("FAIL boundary[%0d]: got bin %0d lat %0d want %0d lat 3",
                     i, out_bin, lat, te[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap;
      int tx[3] = '{-100, 100, 0};
      int ty[3] = '{-1, 0, 0};
      int tr[3] = '{20, 31, 3};
      logic [4:0] te[3] = '{5'd28, 5'd1, 5'd29};
      logic tz[3] = '{1'b0, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 3; i++) begin
         drive_beat(tx[i], ty[i], tr[i]);
         wait_out(lat);
         checks++;
         if (lat != 3 || out_bin !== te[i] || out_zero !== tz[i]) begin
            errors++;
            $display("FAIL wrap[%0d]: got bin %0d zero %b lat %0d want %0d %b lat 3",
                     i, out_bin, out_zero, lat, te[i], tz[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      int tx[8] = '{100, 0, -100, 0, 100, 100, -256, -100};
      int ty[8] = '{0, 100, 0, -100, 20, 100, -256, -1};
      logic [4:0] te[8] = '{5'd0, 5'd8, 5'd16, 5'd24, 5'd1, 5'd4, 5'd20, 5'd16};
      logic [3:0] pat = 4'b1001;
      logic       held = 1'b0;
      logic [4:0] hb = '0;
      int idx = 0, got = 0, cyc = 0;
      while (got < 8 && cyc < 200) begin
         out_ready = pat[cyc % 4];
         in_valid  = (idx < 8);
         if (idx < 8) begin
            dx      = tx[idx][W-1:0];
            dy      = ty[idx][W-1:0];
            ref_bin = '0;
         end
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp in_ready cyc %0d: got %b ov %b or %b",
                     cyc, in_ready, out_valid, out_ready);
         end
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_bin !== hb) begin
               errors++;
               $display("FAIL bp hold cyc %0d: got %b/%0d want 1/%0d",
                        cyc, out_valid, out_bin, hb);
            end
         end
         held = out_valid && !out_ready;
         hb   = out_bin;
         if (out_valid && out_ready) begin
            checks++;
            if (out_bin !== te[got]) begin
               errors++;
               $display("FAIL bp order[%0d]: got %0d want %0d", got, out_bin, te[got]);
            end
            got++;
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL bp count: got %0d beats want 8", got);
      end
      repeat (4) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp extra beat: got out_valid %b want 0", out_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      localparam int N = 200;
      logic [5:0] sb[$];
      logic [5:0] e;
      int x, y, r;
      int sent = 0, got = 0, cyc = 0;
      out_ready = 1'b1;
      while (got < N && cyc < N + 50) begin
         in_valid = (sent < N);
         if (sent < N) begin
            x       = int'($urandom_range(0, 511)) - 256;
            y       = int'($urandom_range(0, 511)) - 256;
            r       = int'($urandom_range(0, 31));
            dx      = x[W-1:0];
            dy      = y[W-1:0];
            ref_bin = r[BW-1:0];
         end
         #1;
         if (out_valid) begin
            e = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
            checks++;
            if ({out_zero, out_bin} !== e) begin
               errors++;
               $display("FAIL sweep[%0d]: got %b/%0d want %b/%0d",
                        got, out_zero, out_bin, e[5], e[4:0]);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(x, y, r));
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != N || cyc != N + 3) begin
         errors++;
         $display("FAIL sweep throughput: got %0d beats in %0d cycles want %0d in %0d",
                  got, cyc, N, N + 3);
      end
   endtask

   task automatic test_reset_midstream;
      int tx[3] = '{100, 0, -100};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dx       = tx[i][W-1:0];
         dy       = 9'd50;
         ref_bin  = '0;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst setup: got out_valid %b want 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_bin !== 5'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst async: got ov %b bin %0d ir %b want 0 0 1",
                  out_valid, out_bin, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst stale: got out_valid %b want 0", out_valid);
         end
      end
   endtask

`ifdef SIFT_DIR_MAG_EN
   task automatic test_mag;
      int tx[3] = '{100, -256, 0};
      int ty[3] = '{20, -256, 0};
      logic [W:0] tm[3] = '{10'd110, 10'd384, 10'd0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         drive_beat(tx[i], ty[i], 0);
         wait_out(lat);
         checks++;
         if (lat != 3 || out_mag !== tm[i]) begin
            errors++;
            $display("FAIL mag[%0d]: got %0d lat %0d want %0d lat 3",
                     i, out_mag, lat, tm[i]);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_axes;
      test_boundaries;
      test_wrap;
      test_backpressure;
      test_back_to_back;
      test_reset_midstream;
`ifdef SIFT_DIR_MAG_EN
      test_mag;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
